// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: occupancy-coded state
// encoding and default channel widths.
package pipe_pkg;

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 12;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned CSR_AW     = 12;
    localparam int unsigned GPR_AW     = 5;

endpackage

// File: rtl/pipe_entry_reg.sv
// NCH-channel write-entry register (data, address, enable) with load and clear.
// Clear wins over load so a flushed slot always reads as a bubble.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned NCH    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  clear_i,
    input  logic [NCH*DATA_W-1:0] wdata_i,
    input  logic [NCH*ADDR_W-1:0] waddr_i,
    input  logic [NCH-1:0]        we_i,
    output logic [NCH*DATA_W-1:0] wdata_o,
    output logic [NCH*ADDR_W-1:0] waddr_o,
    output logic [NCH-1:0]        we_o
);

    logic [NCH*DATA_W-1:0] wdata_q;
    logic [NCH*ADDR_W-1:0] waddr_q;
    logic [NCH-1:0]        we_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdata_q <= '0;
            waddr_q <= '0;
            we_q    <= '0;
        end else if (clear_i) begin
            wdata_q <= '0;
            waddr_q <= '0;
            we_q    <= '0;
        end else if (load_i) begin
            wdata_q <= wdata_i;
            waddr_q <= waddr_i;
            we_q    <= we_i;
        end
    end

    assign wdata_o = wdata_q;
    assign waddr_o = waddr_q;
    assign we_o    = we_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Upstream ready depends only on local state and stall, never on out_ready_i.
module pipe_stage_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned NCH    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [NCH*DATA_W-1:0] in_wdata_i,
    input  logic [NCH*ADDR_W-1:0] in_waddr_i,
    input  logic [NCH-1:0]        in_we_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [NCH*DATA_W-1:0] out_wdata_o,
    output logic [NCH*ADDR_W-1:0] out_waddr_o,
    output logic [NCH-1:0]        out_we_o,
    input  logic                  fc_stall_i,
    input  logic                  fc_flush_i,
    output logic [1:0]            occ_o
);

    pipe_state_e state_q, state_d;

    logic main_load, main_clr, main_from_skid;
    logic skid_load, skid_clr;
    logic skid_valid, accept, emit;

    logic [NCH*DATA_W-1:0] skid_wdata, main_wdata_d;
    logic [NCH*ADDR_W-1:0] skid_waddr, main_waddr_d;
    logic [NCH-1:0]        skid_we, main_we_d;

    assign skid_valid  = (state_q == ST_TWO);
    assign out_valid_o = (state_q != ST_EMPTY);
    assign occ_o       = state_q;

    assign in_ready_o = !rst && !skid_valid && !fc_stall_i;
    assign accept     = in_valid_i && in_ready_o;
    assign emit       = out_valid_o && out_ready_i && !fc_stall_i;

    // Main refills from skid when draining TWO, otherwise from the input.
    assign main_wdata_d = main_from_skid ? skid_wdata : in_wdata_i;
    assign main_waddr_d = main_from_skid ? skid_waddr : in_waddr_i;
    assign main_we_d    = main_from_skid ? skid_we    : in_we_i;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (!fc_stall_i) begin
            if (fc_flush_i) begin
                state_d  = ST_EMPTY;
                main_clr = 1'b1;
                skid_clr = 1'b1;
            end else begin
                unique case (state_q)
                    ST_EMPTY: begin
                        if (accept) begin
                            main_load = 1'b1;
                            state_d   = ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (accept && emit) begin
                            main_load = 1'b1;
                        end else if (accept) begin
                            skid_load = 1'b1;
                            state_d   = ST_TWO;
                        end else if (emit) begin
                            main_clr = 1'b1;
                            state_d  = ST_EMPTY;
                        end
                    end
                    ST_TWO: begin
                        if (emit) begin
                            main_load      = 1'b1;
                            main_from_skid = 1'b1;
                            skid_clr       = 1'b1;
                            state_d        = ST_ONE;
                        end
                    end
                    default: begin
                        state_d  = ST_EMPTY;
                        main_clr = 1'b1;
                        skid_clr = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_entry_reg #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NCH    (NCH)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .load_i  (main_load),
        .clear_i (main_clr),
        .wdata_i (main_wdata_d),
        .waddr_i (main_waddr_d),
        .we_i    (main_we_d),
        .wdata_o (out_wdata_o),
        .waddr_o (out_waddr_o),
        .we_o    (out_we_o)
    );

    pipe_entry_reg #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NCH    (NCH)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .clear_i (skid_clr),
        .wdata_i (in_wdata_i),
        .waddr_i (in_waddr_i),
        .we_i    (in_we_i),
        .wdata_o (skid_wdata),
        .waddr_o (skid_waddr),
        .we_o    (skid_we)
    );

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Randomized and directed bench for pipe_stage_skid_reg, checked against a
// queue-based model of a 2-deep FIFO stage with stall/flush.
module tb_pipe_stage_skid_reg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned NCH    = 2;
    localparam int unsigned DW     = NCH * DATA_W;
    localparam int unsigned AW     = NCH * ADDR_W;

    typedef struct packed {
        logic [NCH-1:0] we;
        logic [AW-1:0]  wa;
        logic [DW-1:0]  wd;
    } ent_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid_i, in_ready_o, out_valid_o, out_ready_i;
    logic [DW-1:0]  in_wdata_i, out_wdata_o;
    logic [AW-1:0]  in_waddr_i, out_waddr_o;
    logic [NCH-1:0] in_we_i, out_we_o;
    logic           fc_stall_i, fc_flush_i;
    logic [1:0]     occ_o;

    int   n_checks = 0;
    int   n_errors = 0;
    ent_t q[$];

    always #5 clk = ~clk;

    pipe_stage_skid_reg #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NCH    (NCH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_wdata_i  (in_wdata_i),
        .in_waddr_i  (in_waddr_i),
        .in_we_i     (in_we_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_wdata_o (out_wdata_o),
        .out_waddr_o (out_waddr_o),
        .out_we_o    (out_we_o),
        .fc_stall_i  (fc_stall_i),
        .fc_flush_i  (fc_flush_i),
        .occ_o       (occ_o)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_valid"}, out_valid_o, 1'b0);
        check_eq({tag, "_wdata"}, out_wdata_o, '0);
        check_eq({tag, "_waddr"}, out_waddr_o, '0);
        check_eq({tag, "_we"}, out_we_o, '0);
        check_eq({tag, "_occ"}, occ_o, 2'd0);
    endtask

    // One cycle: drive after negedge, check vs model, then advance model at posedge.
    task automatic step(input logic v, input logic [DW-1:0] wd, input logic [AW-1:0] wa,
                        input logic [NCH-1:0] we, input logic rdy, input logic st,
                        input logic fl);
        ent_t h;
        ent_t e;
        int   n;
        @(negedge clk);
        in_valid_i  = v;
        in_wdata_i  = wd;
        in_waddr_i  = wa;
        in_we_i     = we;
        out_ready_i = rdy;
        fc_stall_i  = st;
        fc_flush_i  = fl;
        #1;
        n = q.size();
        h = (n > 0) ? q[0] : '0;
        check_eq("out_valid", out_valid_o, n > 0);
        check_eq("out_wdata", out_wdata_o, h.wd);
        check_eq("out_waddr", out_waddr_o, h.wa);
        check_eq("out_we", out_we_o, h.we);
        check_eq("occ", occ_o, n);
        check_eq("in_ready", in_ready_o, (n < 2) && !st);
        @(posedge clk);
        e.wd = wd;
        e.wa = wa;
        e.we = we;
        if (!st) begin
            if (fl) begin
                q.delete();
            end else begin
                if (n > 0 && rdy) void'(q.pop_front());
                if (v && n < 2) q.push_back(e);
            end
        end
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, '0, '0, '0, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        rst         = 1'b1;
        in_valid_i  = 1'b0;
        in_wdata_i  = '0;
        in_waddr_i  = '0;
        in_we_i     = '0;
        out_ready_i = 1'b0;
        fc_stall_i  = 1'b0;
        fc_flush_i  = 1'b0;
        #12;
        check_idle_outputs("rst");
        check_eq("rst_in_ready", in_ready_o, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("post_rst_in_ready", in_ready_o, 1'b1);

        // Streaming: 1 entry/cycle with out_ready held high.
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, {32'h0, 32'(i * 'h11)}, {12'h0, 12'(i)}, 2'b01, 1'b1, 1'b0, 1'b0);
        end
        idle(1'b1);
        idle(1'b1);

        // Backpressure: A,B accepted, C held until space frees.
        step(1'b1, {32'hA1, 32'hA0}, {12'hA1, 12'hA0}, 2'b11, 1'b0, 1'b0, 1'b0);
        step(1'b1, {32'hB1, 32'hB0}, {12'hB1, 12'hB0}, 2'b11, 1'b0, 1'b0, 1'b0);
        step(1'b1, {32'hC1, 32'hC0}, {12'hC1, 12'hC0}, 2'b11, 1'b0, 1'b0, 1'b0);
        step(1'b1, {32'hC1, 32'hC0}, {12'hC1, 12'hC0}, 2'b11, 1'b1, 1'b0, 1'b0);
        step(1'b1, {32'hC1, 32'hC0}, {12'hC1, 12'hC0}, 2'b11, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Stall + flush in TWO: stall wins, then flush alone empties.
        step(1'b1, {32'h1, 32'h2}, {12'h1, 12'h2}, 2'b11, 1'b0, 1'b0, 1'b0);
        step(1'b1, {32'h3, 32'h4}, {12'h3, 12'h4}, 2'b11, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b1);
        step(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b1);
        step(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
        #1;
        check_idle_outputs("flush_after_stall");

        // Flush with an entry offered in ONE: offered entry is dropped.
        step(1'b1, {32'h5, 32'h6}, {12'h5, 12'h6}, 2'b01, 1'b0, 1'b0, 1'b0);
        step(1'b1, {32'h0, 32'hDEADBEEF}, {12'h0, 12'h7}, 2'b01, 1'b0, 1'b0, 1'b1);
        #1;
        check_idle_outputs("flush_drop");
        idle(1'b1);

        // CSR channel only.
        step(1'b1, {32'h8, 32'h0}, {12'h300, 12'h0}, 2'b10, 1'b0, 1'b0, 1'b0);
        #1;
        check_eq("csr_we", out_we_o, 2'b10);
        check_eq("csr_wdata", out_wdata_o[DATA_W +: DATA_W], 32'h8);
        check_eq("csr_waddr", out_waddr_o[ADDR_W +: ADDR_W], 12'h300);
        idle(1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 6), {$urandom(), $urandom()},
                 AW'({$urandom(), $urandom()}), NCH'($urandom()),
                 ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 19) == 0));
        end

        // Async reset mid-stream from TWO.
        step(1'b1, {32'h77, 32'h66}, {12'h77, 12'h66}, 2'b11, 1'b0, 1'b0, 1'b1);
        step(1'b1, {32'h99, 32'h88}, {12'h99, 12'h88}, 2'b11, 1'b0, 1'b0, 1'b0);
        step(1'b1, {32'hBB, 32'hAA}, {12'hBB, 12'hAA}, 2'b11, 1'b0, 1'b0, 1'b0);
        #1;
        check_eq("pre_rst_occ", occ_o, 2'd2);
        #1;
        rst        = 1'b1;
        in_valid_i = 1'b0;
        fc_flush_i = 1'b0;
        fc_stall_i = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        check_eq("async_rst_in_ready", in_ready_o, 1'b0);
        q.delete();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_eq("rst_release_in_ready", in_ready_o, 1'b1);
        step(1'b1, {32'h12, 32'h34}, {12'h12, 12'h34}, 2'b11, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
